// File: rtl/bitbakery_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among four word producers.
// Latches the winning word, pulses the transmitter start, waits for done or timeout, then idles for GAP cycles.
module bitbakery_tx_arbiter #(
    parameter int GAP     = 16,
    parameter int TIMEOUT = 100000,
    parameter int N       = 32
) (
    input  logic       clock,
    input  logic       reset_in,
    input  logic [3:0] req,
    input  logic [7:0] D0,
    input  logic [7:0] D1,
    input  logic [7:0] D2,
    input  logic [7:0] D3,
    input  logic       tx_pronto,
    input  logic       clear_erro,
    output logic [3:0] grant,
    output logic       tx_partida,
    output logic [7:0] tx_dados,
    output logic       busy,
    output logic       erro,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_START = 3'b001,
        S_WAIT  = 3'b010,
        S_GAP   = 3'b011
    } state_t;

    localparam logic [N-1:0] TIMEOUT_LAST = N'(TIMEOUT - 1);
    localparam logic [N-1:0] GAP_LAST     = N'((GAP > 0) ? GAP - 1 : 0);

    state_t         state_reg, state_next;
    logic [N-1:0]   count_reg, count_next;
    logic [1:0]     last_reg, last_next;
    logic [3:0]     grant_reg, grant_next;
    logic [7:0]     data_reg, data_next;
    logic           erro_reg, erro_next;

    logic [7:0]     words [4];
    logic [1:0]     rot_idx [4];
    logic [3:0]     rot_req;
    logic [1:0]     win_idx;

    assign words[0] = D0;
    assign words[1] = D1;
    assign words[2] = D2;
    assign words[3] = D3;

    // Requests viewed in priority order starting just after the last winner.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rotate
            assign rot_idx[gi] = last_reg + 2'(gi + 1);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_idx = rot_idx[0];
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) win_idx = rot_idx[k];
        end
    end

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
            last_reg  <= 2'd3;
            grant_reg <= 4'b0000;
            data_reg  <= 8'h00;
            erro_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            last_reg  <= last_next;
            grant_reg <= grant_next;
            data_reg  <= data_next;
            erro_reg  <= erro_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        last_next  = last_reg;
        grant_next = 4'b0000;
        data_next  = data_reg;
        erro_next  = erro_reg;
        if (clear_erro) erro_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (|req) begin
                    state_next = S_START;
                    data_next  = words[win_idx];
                    grant_next = 4'b0001 << win_idx;
                    last_next  = win_idx;
                end
            end
            S_START: begin
                state_next = S_WAIT;
                count_next = '0;
            end
            S_WAIT: begin
                if (tx_pronto || count_reg == TIMEOUT_LAST) begin
                    // A timeout set takes precedence over a simultaneous clear.
                    if (!tx_pronto) erro_next = 1'b1;
                    state_next = (GAP == 0) ? S_IDLE : S_GAP;
                    count_next = '0;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            S_GAP: begin
                if (count_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                    count_next = '0;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase
    end

    assign grant      = grant_reg;
    assign tx_partida = (state_reg == S_START);
    assign tx_dados   = data_reg;
    assign busy       = (state_reg != S_IDLE);
    assign erro       = erro_reg;
    assign db_estado  = state_reg;

endmodule

// File: tb/tb_bitbakery_tx_arbiter.sv
// Bench for bitbakery_tx_arbiter: scenario tasks checked against a round-robin/timing model derived from the rules.
module tb_bitbakery_tx_arbiter;

    localparam int GAP     = 16;
    localparam int TIMEOUT = 20;

    logic       clock = 1'b0;
    logic       reset_in = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [7:0] D0 = 8'h00, D1 = 8'h00, D2 = 8'h00, D3 = 8'h00;
    logic       tx_pronto = 1'b0;
    logic       clear_erro = 1'b0;
    logic [3:0] grant;
    logic       tx_partida;
    logic [7:0] tx_dados;
    logic       busy;
    logic       erro;
    logic [2:0] db_estado;

    int n_cmp = 0;
    int n_err = 0;
    int last_m = 3;

    bitbakery_tx_arbiter #(.GAP(GAP), .TIMEOUT(TIMEOUT), .N(32)) dut (
        .clock(clock), .reset_in(reset_in), .req(req),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .tx_pronto(tx_pronto), .clear_erro(clear_erro),
        .grant(grant), .tx_partida(tx_partida), .tx_dados(tx_dados),
        .busy(busy), .erro(erro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Round-robin rule: first pending requester after the previous winner, modulo 4.
    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        reset_in   = 1'b0;
        req        = 4'b0000;
        tx_pronto  = 1'b0;
        clear_erro = 1'b0;
        repeat (2) @(negedge clock);
        reset_in = 1'b1;
        last_m   = 3;
    endtask

    // Runs one word: waits for a grant, then steps to IDLE, pulsing tx_pronto in WAIT cycle pronto_at (0 = never).
    task automatic do_word(input int pronto_at, input bit pronto_in_start,
                           input logic [3:0] req_after, input logic [3:0] req_wait,
                           output logic [3:0] g, output logic [7:0] d,
                           output int partida_n, output int busy_n, output int wait_n,
                           output int gap_n, output bit stable, output int erro_at);
        logic [7:0] saved [4];
        bit got;
        g = 4'b0000; d = 8'h00; partida_n = 0; busy_n = 0; wait_n = 0; gap_n = 0;
        stable = 1'b1; erro_at = -1; got = 1'b0;
        saved = '{D0, D1, D2, D3};
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (grant != 4'b0000) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            g = grant; d = tx_dados; partida_n = int'(tx_partida); busy_n = 1;
            req = req_after;
            tx_pronto = pronto_in_start;
            for (int i = 0; i < 200; i++) begin
                @(negedge clock);
                tx_pronto = 1'b0;
                if (!busy) break;
                busy_n++;
                partida_n += int'(tx_partida);
                if (erro && erro_at < 0) erro_at = wait_n;
                if (db_estado == 3'b010) begin
                    wait_n++;
                    if (tx_dados !== d) stable = 1'b0;
                    if (wait_n == 1) begin
                        req = req_wait;
                        D0 = 8'($urandom); D1 = 8'($urandom); D2 = 8'($urandom); D3 = 8'($urandom);
                    end
                    if (wait_n == pronto_at) tx_pronto = 1'b1;
                end else if (db_estado == 3'b011) begin
                    gap_n++;
                    D0 = saved[0]; D1 = saved[1]; D2 = saved[2]; D3 = saved[3];
                end
            end
        end
        $display("word: grant=%b data=%h partida=%0d busy=%0d wait=%0d gap=%0d erro=%b",
                 g, d, partida_n, busy_n, wait_n, gap_n, erro);
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        #1;
        n_cmp++; if (db_estado !== 3'b000) begin n_err++; $display("FAIL reset_state got=%b exp=000", db_estado); end
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        n_cmp++; if (tx_partida !== 1'b0) begin n_err++; $display("FAIL reset_partida got=%b exp=0", tx_partida); end
        n_cmp++; if (tx_dados !== 8'h00) begin n_err++; $display("FAIL reset_dados got=%h exp=00", tx_dados); end
        n_cmp++; if ({busy, erro} !== 2'b00) begin n_err++; $display("FAIL reset_busy_erro got=%b exp=00", {busy, erro}); end
        apply_reset();
        repeat (3) @(negedge clock);
        n_cmp++; if ({busy, grant} !== 5'b0) begin n_err++; $display("FAIL idle_no_req got=%b exp=00000", {busy, grant}); end
    endtask

    task automatic test_single();
        logic [3:0] g; logic [7:0] d; int pn, bn, wn, gn, ea; bit st;
        apply_reset();
        D0 = 8'h2A; req = 4'b0001;
        do_word(6, 1'b0, 4'b0000, 4'b0000, g, d, pn, bn, wn, gn, st, ea);
        n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL single_grant got=%b exp=0001", g); end
        n_cmp++; if (d !== 8'h2A) begin n_err++; $display("FAIL single_data got=%h exp=2a", d); end
        n_cmp++; if (pn !== 1) begin n_err++; $display("FAIL single_partida_cycles got=%0d exp=1", pn); end
        n_cmp++; if (bn !== 1 + 6 + GAP) begin n_err++; $display("FAIL single_busy_cycles got=%0d exp=%0d", bn, 1 + 6 + GAP); end
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL single_data_stable got=%b exp=1", st); end
        repeat (3) @(negedge clock);
        n_cmp++; if ({busy, grant} !== 5'b0) begin n_err++; $display("FAIL single_no_regrant got=%b exp=00000", {busy, grant}); end
    endtask

    task automatic test_round_robin();
        logic [3:0] g; logic [7:0] d; int pn, bn, wn, gn, ea, ex; bit st;
        logic [7:0] vals [4];
        vals = '{8'h00, 8'h51, 8'h92, 8'hC0};
        apply_reset();
        D0 = vals[0]; D1 = vals[1]; D2 = vals[2]; D3 = vals[3];
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            ex = pick(4'b1111, last_m);
            do_word(3, 1'b0, (j == 4) ? 4'b0000 : 4'b1111, (j == 4) ? 4'b0000 : 4'b1111,
                    g, d, pn, bn, wn, gn, st, ea);
            n_cmp++; if (g !== 4'(1 << ex)) begin n_err++; $display("FAIL rr_grant_%0d got=%b exp=%b", j, g, 4'(1 << ex)); end
            n_cmp++; if (d !== vals[ex]) begin n_err++; $display("FAIL rr_data_%0d got=%h exp=%h", j, d, vals[ex]); end
            last_m = ex;
        end
    endtask

    task automatic test_late_request();
        logic [3:0] g; logic [7:0] d, d2v; int pn, bn, wn, gn, ea; bit st;
        apply_reset();
        d2v = 8'($urandom); D2 = d2v; D3 = 8'h3C;
        req = 4'b0100;
        do_word(5, 1'b0, 4'b0100, 4'b1000, g, d, pn, bn, wn, gn, st, ea);
        n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL late_first_grant got=%b exp=0100", g); end
        n_cmp++; if (d !== d2v || st !== 1'b1) begin n_err++; $display("FAIL late_data_hold got=%h/%b exp=%h/1", d, st, d2v); end
        n_cmp++; if (gn !== GAP || bn !== 1 + 5 + GAP) begin n_err++; $display("FAIL late_gap got=%0d/%0d exp=%0d/%0d", gn, bn, GAP, 1 + 5 + GAP); end
        do_word(4, 1'b0, 4'b0000, 4'b0000, g, d, pn, bn, wn, gn, st, ea);
        n_cmp++; if (g !== 4'b1000 || d !== 8'h3C) begin n_err++; $display("FAIL late_second got=%b/%h exp=1000/3c", g, d); end
    endtask

    task automatic test_timeout();
        logic [3:0] g; logic [7:0] d; int pn, bn, wn, gn, ea; bit st;
        apply_reset();
        req = 4'b0001;
        do_word(0, 1'b0, 4'b0000, 4'b0000, g, d, pn, bn, wn, gn, st, ea);
        n_cmp++; if (ea !== TIMEOUT || wn !== TIMEOUT) begin n_err++; $display("FAIL timeout_rise got=%0d/%0d exp=%0d", ea, wn, TIMEOUT); end
        n_cmp++; if (gn !== GAP) begin n_err++; $display("FAIL timeout_gap got=%0d exp=%0d", gn, GAP); end
        req = 4'b0010;
        do_word(4, 1'b0, 4'b0000, 4'b0000, g, d, pn, bn, wn, gn, st, ea);
        n_cmp++; if (g !== 4'b0010 || erro !== 1'b1) begin n_err++; $display("FAIL timeout_sticky got=%b/%b exp=0010/1", g, erro); end
        clear_erro = 1'b1;
        @(negedge clock);
        clear_erro = 1'b0;
        n_cmp++; if (erro !== 1'b0) begin n_err++; $display("FAIL timeout_clear got=%b exp=0", erro); end
    endtask

    task automatic test_pronto_in_start();
        logic [3:0] g; logic [7:0] d; int pn, bn, wn, gn, ea; bit st;
        apply_reset();
        req = 4'b0001;
        do_word(3, 1'b1, 4'b0000, 4'b0000, g, d, pn, bn, wn, gn, st, ea);
        n_cmp++; if (wn !== 3 || bn !== 1 + 3 + GAP) begin n_err++; $display("FAIL start_pronto got=%0d/%0d exp=3/%0d", wn, bn, 1 + 3 + GAP); end
    endtask

    task automatic test_reset_mid_wait();
        logic [3:0] g; logic [7:0] d; int pn, bn, wn, gn, ea; bit st;
        bit seen;
        apply_reset();
        D1 = 8'h77; D2 = 8'h99;
        req = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            req = 4'b0000;
            if (db_estado == 3'b010) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL midwait_reach got=0 exp=1"); end
        #2 reset_in = 1'b0;
        #1;
        n_cmp++; if ({db_estado, busy, grant, tx_partida, tx_dados, erro} !== 18'b0) begin
            n_err++; $display("FAIL midwait_async got=%b exp=0", {db_estado, busy, grant, tx_partida, tx_dados, erro});
        end
        @(negedge clock);
        req = 4'b1010;
        reset_in = 1'b1;
        last_m = 3;
        do_word(2, 1'b0, 4'b0000, 4'b0000, g, d, pn, bn, wn, gn, st, ea);
        n_cmp++; if (g !== 4'(1 << pick(4'b1010, last_m)) || d !== 8'h77) begin
            n_err++; $display("FAIL midwait_first got=%b/%h exp=0010/77", g, d);
        end
    endtask

    task automatic test_random();
        logic [3:0] g, r; logic [7:0] d; int pn, bn, wn, gn, ea, ex, pa; bit st;
        logic [7:0] vals [4];
        apply_reset();
        for (int j = 0; j < 20; j++) begin
            r = 4'($urandom_range(1, 15));
            pa = $urandom_range(1, TIMEOUT - 1);
            vals = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            D0 = vals[0]; D1 = vals[1]; D2 = vals[2]; D3 = vals[3];
            req = r;
            ex = pick(r, last_m);
            do_word(pa, 1'b0, r, r, g, d, pn, bn, wn, gn, st, ea);
            n_cmp++; if (g !== 4'(1 << ex) || d !== vals[ex]) begin
                n_err++; $display("FAIL rand_%0d_word got=%b/%h exp=%b/%h", j, g, d, 4'(1 << ex), vals[ex]);
            end
            n_cmp++; if (bn !== 1 + pa + GAP || st !== 1'b1) begin
                n_err++; $display("FAIL rand_%0d_timing got=%0d/%b exp=%0d/1", j, bn, st, 1 + pa + GAP);
            end
            last_m = ex;
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_late_request();
        test_timeout();
        test_pronto_in_start();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
